wb_gpio_irq_ctrl: RTL and testbench

Interrupt controller and configuration block for the Wishbone GPIO port. It synchronises the raw GPIO inputs and detects edges or levels per pin under software control. It keeps sticky pending bits and drives a single registered interrupt line to the system interrupt controller. Software configures it through a small Wishbone-slave register file sharing the bus conventions of wb_gpio.

---
 rtl/wb_gpio_pkg.sv | 14 +
 rtl/wb_gpio_sync.sv | 34 +++
 rtl/wb_gpio_irq_ctrl.sv | 99 +++++++++
 tb/tb_wb_gpio_irq_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_gpio_pkg.sv
// Shared constants for the Wishbone GPIO blocks: register word map and default bus widths.
package wb_gpio_pkg;

  localparam int GPIO_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [2:0] ADDR_INPUT = 3'd0;
  localparam logic [2:0] ADDR_MASK  = 3'd1;
  localparam logic [2:0] ADDR_MODE  = 3'd2;
  localparam logic [2:0] ADDR_POL   = 3'd3;
  localparam logic [2:0] ADDR_PEND  = 3'd4;
  localparam logic [2:0] ADDR_STAT  = 3'd5;

endpackage

// File: rtl/wb_gpio_sync.sv
// Two-flop synchroniser plus history flop per pin; rise/fall are single-cycle events off s2/s3.
// Latency: s2 reflects a pin two edges after it is first sampled; no backpressure.
module wb_gpio_sync
  import wb_gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] s2_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= gpio_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign s2_o   = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/wb_gpio_irq_ctrl.sv
// GPIO interrupt controller: per-pin edge/level detect, sticky W1C pending, registered irq_o, Wishbone regs.
// Latency: ack one edge after stb, irq_o three edges after a pin change is sampled; strobes never stalled.
module wb_gpio_irq_ctrl
  import wb_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH = GPIO_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [2:0]            adr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic                  irq_o
);

  logic [GPIO_WIDTH-1:0] s2, rise, fall;
  logic [GPIO_WIDTH-1:0] mask_q, mask_d, mode_q, mode_d, pol_q, pol_d, pend_q, pend_d;
  logic [GPIO_WIDTH-1:0] wdat, clr, set, rd_sel;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ack_q, irq_q, bus_req, wr_en;
  logic                  unused_data;

  wb_gpio_sync #(.WIDTH(GPIO_WIDTH)) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .gpio_i (gpio_i),
    .s2_o   (s2),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Bits above GPIO_WIDTH have no storage; the fold keeps them formally consumed.
  assign unused_data = ^data_i;

  always_comb begin
    bus_req = stb_i & ~ack_q;
    wr_en   = bus_req & we_i;
    wdat    = data_i[GPIO_WIDTH-1:0];

    rd_sel = '0;
    case (adr_i)
      ADDR_INPUT: rd_sel = s2;
      ADDR_MASK:  rd_sel = mask_q;
      ADDR_MODE:  rd_sel = mode_q;
      ADDR_POL:   rd_sel = pol_q;
      ADDR_PEND:  rd_sel = pend_q;
      ADDR_STAT:  rd_sel = pend_q & mask_q;
      default:    rd_sel = '0;
    endcase
    data_d = (bus_req & ~we_i) ? DATA_WIDTH'(rd_sel) : '0;

    mask_d = mask_q;
    mode_d = mode_q;
    pol_d  = pol_q;
    if (wr_en) begin
      case (adr_i)
        ADDR_MASK: mask_d = wdat;
        ADDR_MODE: mode_d = wdat;
        ADDR_POL:  pol_d  = wdat;
        default:   ;
      endcase
    end

    // Set is ORed in after the clear so a same-cycle event survives a W1C.
    clr    = (wr_en && adr_i == ADDR_PEND) ? wdat : '0;
    set    = (mode_q & ((pol_q & rise) | (~pol_q & fall))) | (~mode_q & ~(s2 ^ pol_q));
    pend_d = (pend_q & ~clr) | set;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q  <= 1'b0;
      data_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
      pol_q  <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ack_q  <= bus_req;
      data_q <= data_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      pol_q  <= pol_d;
      pend_q <= pend_d;
      irq_q  <= |(pend_q & mask_q);
    end
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq_ctrl.sv
// Directed bench for wb_gpio_irq_ctrl: bus expectations go through a scoreboard popped by an ack monitor.
module tb_wb_gpio_irq_ctrl;
  import wb_gpio_pkg::*;

  localparam int GW = 8;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          stb_i = 1'b0;
  logic          we_i  = 1'b0;
  logic [2:0]    adr_i = 3'd0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic          ack_o;
  logic [GW-1:0] gpio_i = '0;
  logic          irq_o;

  wb_gpio_irq_ctrl #(.GPIO_WIDTH(GW), .DATA_WIDTH(DW)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .stb_i  (stb_i),
    .we_i   (we_i),
    .adr_i  (adr_i),
    .data_i (data_i),
    .data_o (data_o),
    .ack_o  (ack_o),
    .gpio_i (gpio_i),
    .irq_o  (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit            rd;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sb[$];

  bit mon_en   = 1'b0;
  bit ack_prev = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wb(input bit we, input logic [2:0] a, input logic [DW-1:0] d, input logic [DW-1:0] exp);
    @(posedge clk_i);
    #1;
    chk("ack_idle_before_stb", DW'(ack_o), 32'h0);
    stb_i = 1'b1;
    we_i  = we;
    adr_i = a;
    data_i = d;
    sb.push_back('{rd: !we, d: exp});
    @(posedge clk_i);
    #1;
    chk("ack_one_cycle_after_stb", DW'(ack_o), 32'h1);
    stb_i = 1'b0;
    we_i  = 1'b0;
    data_i = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
    wb(1'b1, a, d, 32'h0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [DW-1:0] exp);
    wb(1'b0, a, 32'h0, exp);
  endtask

  task automatic chk_irq(input string nm, input logic exp);
    chk(nm, DW'(irq_o), DW'(exp));
  endtask

  // Monitor: every ack consumes one scoreboard entry; reads compare data_o.
  always @(negedge clk_i) begin
    exp_t e;
    if (mon_en) begin
      if (ack_o) begin
        if (ack_prev) begin
          checks++;
          errors++;
          $display("FAIL ack_width: ack high on two consecutive cycles");
        end
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: ack with empty scoreboard");
        end else begin
          e = sb.pop_front();
          if (e.rd) chk("read_data", data_o, e.d);
        end
      end else begin
        chk("data_idle_zero", data_o, 32'h0);
      end
      ack_prev = ack_o;
    end
  end

  initial begin
    // Reset held with a strobe and all pins high.
    rst_i  = 1'b0;
    stb_i  = 1'b1;
    gpio_i = 8'hFF;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack", DW'(ack_o), 32'h0);
    chk("rst_irq", DW'(irq_o), 32'h0);
    chk("rst_data", data_o, 32'h0);
    stb_i = 1'b0;
    @(negedge clk_i);
    rst_i  = 1'b1;
    mon_en = 1'b1;

    rd(ADDR_MASK, 32'h0);
    rd(ADDR_MODE, 32'h0);
    rd(ADDR_POL,  32'h0);
    rd(ADDR_STAT, 32'h0);
    rd(ADDR_INPUT, 32'h0000_00FF);

    // Register access and width truncation.
    gpio_i = 8'h00;
    wr(ADDR_MASK, 32'h0000_00A5);
    rd(ADDR_MASK, 32'h0000_00A5);
    wr(ADDR_MASK, 32'hFFFF_FFFF);
    rd(ADDR_MASK, 32'h0000_00FF);
    wr(ADDR_MASK, 32'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'h0);
    wr(ADDR_INPUT, 32'h0000_00FF);
    rd(ADDR_INPUT, 32'h0);
    cyc(3);

    // Rising-edge interrupt on pin 0.
    wr(ADDR_MODE, 32'h01);
    wr(ADDR_POL,  32'h01);
    cyc(3);
    wr(ADDR_PEND, 32'hFF);
    wr(ADDR_MASK, 32'h01);
    cyc(3);
    chk_irq("rise_irq_idle", 1'b0);
    gpio_i = 8'h01;
    cyc(2);
    chk_irq("rise_irq_k1", 1'b0);
    cyc(1);
    chk_irq("rise_irq_k2", 1'b0);
    cyc(1);
    chk_irq("rise_irq_k3", 1'b1);
    rd(ADDR_STAT, 32'h01);
    rd(ADDR_PEND, 32'hFF);
    wr(ADDR_PEND, 32'h01);
    chk_irq("rise_irq_at_clear_edge", 1'b1);
    cyc(1);
    chk_irq("rise_irq_after_clear", 1'b0);
    cyc(5);
    chk_irq("rise_irq_stays_low", 1'b0);
    rd(ADDR_PEND, 32'hFE);

    // Level-low interrupt on pin 1: W1C cannot clear while the level persists.
    wr(ADDR_MODE, 32'h00);
    wr(ADDR_POL,  32'h00);
    wr(ADDR_MASK, 32'h02);
    cyc(2);
    chk_irq("level_irq", 1'b1);
    wr(ADDR_PEND, 32'h02);
    cyc(1);
    chk_irq("level_irq_held", 1'b1);
    rd(ADDR_PEND, 32'hFF);
    gpio_i = 8'h03;
    cyc(4);
    chk_irq("level_sticky_after_release", 1'b1);
    wr(ADDR_PEND, 32'h02);
    cyc(1);
    chk_irq("level_irq_cleared", 1'b0);
    rd(ADDR_PEND, 32'hFD);

    // Falling edge on pin 2 coinciding with its W1C: set wins.
    wr(ADDR_MODE, 32'h04);
    gpio_i = 8'h07;
    cyc(4);
    wr(ADDR_PEND, 32'hFF);
    rd(ADDR_PEND, 32'hF8);
    gpio_i = 8'h03;
    cyc(1);
    wr(ADDR_PEND, 32'h04);
    rd(ADDR_PEND, 32'hFC);

    // Masking gates STAT and irq_o but not PEND.
    wr(ADDR_MODE, 32'hFF);
    wr(ADDR_MASK, 32'h00);
    cyc(3);
    wr(ADDR_PEND, 32'hFF);
    rd(ADDR_PEND, 32'h00);
    gpio_i = 8'h0F;
    cyc(4);
    gpio_i = 8'h03;
    cyc(4);
    rd(ADDR_PEND, 32'h0C);
    rd(ADDR_STAT, 32'h00);
    chk_irq("mask_irq_off", 1'b0);
    wr(ADDR_MASK, 32'h04);
    chk_irq("mask_irq_at_write_edge", 1'b0);
    cyc(1);
    chk_irq("mask_irq_on", 1'b1);
    rd(ADDR_STAT, 32'h04);

    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk_i);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
